// File: rtl/divisor_restoring_param_if.sv
// rtl/divisor_restoring_param_if.sv - request/result bundle for the restoring divider
interface divisor_restoring_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             done;
    logic             busy;
    logic             div_zero;

    modport master (
        output start, signed_mode, A_in, B_in,
        input  Q, R, done, busy, div_zero
    );

    modport slave (
        input  start, signed_mode, A_in, B_in,
        output Q, R, done, busy, div_zero
    );
endinterface

// File: rtl/divisor_restoring_param.sv
// rtl/divisor_restoring_param.sv - multi-cycle restoring divider, one quotient bit per clock
module divisor_restoring_param #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    divisor_restoring_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_done;
    logic             r_busy;
    logic             r_div_zero;

    logic             w_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift_p;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_signed = (SIGNED_EN != 0) && bus.signed_mode;
    assign w_sign_a = w_signed && bus.A_in[WIDTH-1];
    assign w_sign_b = w_signed && bus.B_in[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -bus.A_in : bus.A_in;
    assign w_abs_b  = w_sign_b ? -bus.B_in : bus.B_in;
    assign w_b_zero = (bus.B_in == '0);

    // Extra top bit on the trial difference acts as the borrow / restore decision.
    assign w_shift_p = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_trial   = {1'b0, w_shift_p} - {2'b00, r_b};

    assign w_q_fix = r_neg_q ? -r_a : r_a;
    assign w_r_fix = r_neg_r ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = w_b_zero ? FIX : ITER;
            ITER:    if (r_cnt == CW'(1)) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_orig   <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_a_orig <= bus.A_in;
                        r_p      <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_dz     <= w_b_zero;
                        r_busy   <= 1'b1;
                    end
                end
                ITER: begin
                    r_p   <= w_trial[WIDTH+1] ? w_shift_p : w_trial[WIDTH:0];
                    r_a   <= {r_a[WIDTH-2:0], ~w_trial[WIDTH+1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_div_zero <= r_dz;
                    if (r_dz) begin
                        r_q <= '1;
                        r_r <= r_a_orig;
                    end else begin
                        r_q <= w_q_fix;
                        r_r <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Q        = r_q;
    assign bus.R        = r_r;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.div_zero = r_div_zero;
endmodule

// File: doc/divisor_restoring_param.md
DIVISOR_RESTORING_PARAM -- requirements
Module: divisor_restoring_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; legal range 2..32.
REQ-002 Parameter: SIGNED_EN, default 1; when 0, signed_mode SHALL be ignored and treated as 0.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-007 Port: A_in  input  WIDTH  dividend; captured with start.
REQ-008 Port: B_in  input  WIDTH  divisor; captured with start.
REQ-009 Port: Q  output  WIDTH  quotient, registered.
REQ-010 Port: R  output  WIDTH  remainder, registered.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: busy  output  1  high while an operation is in progress.
REQ-013 Port: div_zero  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-014 FSM states SHALL be IDLE, ITER, FIX; IDLE after reset.
REQ-015 IDLE + start=1 at edge E0: latch operands and mode; latch |A|, |B| (signed) or raw values (unsigned); clear partial remainder; set iteration counter to WIDTH; go to ITER; busy=1 from E0.
REQ-016 ITER: one restoring step per clock: shift {P,A} left 1; trial P-B; if non-negative, keep the difference and set quotient bit to 1; otherwise restore P and set quotient bit to 0; decrement counter.
REQ-017 The partial remainder datapath SHALL be WIDTH+1 bits to hold |B| = 2^(WIDTH-1) without overflow.
REQ-018 After WIDTH ITER steps (edges E1..E_WIDTH), the FSM SHALL go to FIX.
REQ-019 FIX at edge E_(WIDTH+1): apply signs, load Q/R, pulse done=1, drop busy, return to IDLE.
REQ-020 Sign rules: Q negated when sign(A) XOR sign(B) = 1; R takes the sign of A, so that A = Q*B + R and |R| < |B|.
REQ-021 Signed -2^(WIDTH-1) / -1: Q SHALL equal -2^(WIDTH-1) (wrap), R SHALL equal 0, div_zero SHALL equal 0.
REQ-022 Divide by zero (B_in=0 at E0): skip ITER; at E1 load Q = all ones, R = A_in unchanged, div_zero=1, done=1, busy=0, and return to IDLE.
REQ-023 Latency: done high in the cycle after edge E_(WIDTH+1) for normal operation and after E1 for divide by zero.
REQ-024 done SHALL be high for exactly one cycle; Q, R and div_zero SHALL hold until the next completion.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-026 start sampled in the cycle where done=1 SHALL be accepted; back-to-back operations have no idle gap.
REQ-027 Operand inputs SHALL NOT be sampled after E0; changes to them mid-operation SHALL NOT affect the result.

Reset
REQ-028 While rst=1 at an edge: state=IDLE; Q=0, R=0, done=0, busy=0, div_zero=0; counter and datapath cleared.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 rst mid-operation SHALL abort without a done pulse; the next start SHALL run a full operation.

Verification
REQ-031 WIDTH=8, unsigned 127/30 -> Q=4, R=7, done exactly 9 edges after the start edge, busy high for 9 cycles.
REQ-032 WIDTH=8, signed -7/2 -> Q=0xFD (-3), R=0xFF (-1); signed -128/-1 -> Q=0x80, R=0, div_zero=0.
REQ-033 WIDTH=8, 200/0 -> done 1 edge after start, Q=0xFF, R=200, div_zero=1; a following 10/2 -> Q=5, R=0, div_zero=0.
REQ-034 WIDTH=7, unsigned 60/60 -> Q=1, R=0; 0/10 -> Q=0, R=0; 10/2 -> Q=5, R=0.
REQ-035 Assert rst at iteration 3 of 127/30 -> no done pulse, all outputs 0; a later start of 50/7 -> Q=7, R=1.
REQ-036 Pulse start mid-operation with other operands -> ignored, first result unchanged; start during done cycle -> accepted, second result correct.
